core_status: RTL and testbench

Processor status (P) register and interrupt sampler for the 2A03 core, directly downstream of the ALU.
- Latches the ALU's flag outputs and feeds them back as the ALU's incoming flags next cycle.
- Executes flag opcodes, PLP/RTI loads and the push byte.
- Evaluates branch conditions.
- Detects NMI edges and samples the IRQ level at instruction boundaries to request interrupt entry from the sequencer.

---
 rtl/core_status_signals.sv | 49 ++++
 rtl/core_status_irq.sv | 86 ++++++++
 rtl/core_status.sv | 148 ++++++++++++++
 tb/tb_core_status.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_status_signals.sv
// core_status_signals
//   Shared encodings for the 2A03 processor status block: the control word
//   driven by the sequencer, flag opcode and branch-select encodings, the
//   bit positions of each flag inside the P byte and a helper that forms
//   the push byte.
package core_status_signals;

  typedef enum logic [2:0] {
    FLAG_OP_NONE = 3'd0,
    FLAG_OP_CLC  = 3'd1,
    FLAG_OP_SEC  = 3'd2,
    FLAG_OP_CLI  = 3'd3,
    FLAG_OP_SEI  = 3'd4,
    FLAG_OP_CLD  = 3'd5,
    FLAG_OP_SED  = 3'd6,
    FLAG_OP_CLV  = 3'd7
  } flag_op_type;

  // Opcode bits [7:6] of a 6502 branch pick the tested flag.
  typedef enum logic [1:0] {
    BRANCH_SEL_N = 2'd0,
    BRANCH_SEL_V = 2'd1,
    BRANCH_SEL_C = 2'd2,
    BRANCH_SEL_Z = 2'd3
  } branch_sel_type;

  typedef struct packed {
    logic        load_alu;
    logic        load_bus;
    logic        set_i;
    flag_op_type flag_op;
  } status_control_type;

  localparam int STATUS_C = 0;
  localparam int STATUS_Z = 1;
  localparam int STATUS_I = 2;
  localparam int STATUS_D = 3;
  localparam int STATUS_V = 6;
  localparam int STATUS_N = 7;

  // Push byte layout {N,V,1,B,D,I,Z,C}; bit 5 has no storage and reads as 1.
  function automatic logic [7:0] pack_status(
    input logic n, input logic v, input logic b, input logic d,
    input logic i, input logic z, input logic c
  );
    return {n, v, 1'b1, b, d, i, z, c};
  endfunction

endpackage

// File: rtl/core_status_irq.sv
// core_status_irq
//   NMI edge detection and latch, IRQ level gating and the interrupt request
//   register sampled at instruction boundaries.
//
//   Optional feature macro: CORE_STATUS_IRQ_DELAY_EN
//     defined   -> IRQ masking uses a copy of I taken at each poll, so
//                  CLI/SEI/PLP affect masking one instruction late (6502 style)
//     undefined -> IRQ masking uses the live I flag
//
// Ports:
//   clock        core clock
//   reset_n      synchronous active-low reset
//   nmi_n        NMI pin (already synchronised)
//   irq_n        IRQ pin (already synchronised)
//   poll         instruction-boundary strobe
//   nmi_ack      sequencer entered the NMI vector, clears the latch
//   i_flag       registered interrupt-disable flag
//   nmi_pending  NMI latch
//   interrupt    interrupt request captured at the last poll
module core_status_irq (
  input  logic clock,
  input  logic reset_n,
  input  logic nmi_n,
  input  logic irq_n,
  input  logic poll,
  input  logic nmi_ack,
  input  logic i_flag,
  output logic nmi_pending,
  output logic interrupt
);

  logic nmi_sample_q;
  logic nmi_prev_q;
  logic nmi_latch_q;
  logic interrupt_q;
  logic nmi_edge;
  logic i_mask;
  logic irq_req;

`ifdef CORE_STATUS_IRQ_DELAY_EN
  logic delayed_i_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      delayed_i_q <= 1'b1;
    end else if (poll) begin
      delayed_i_q <= i_flag;
    end
  end

  assign i_mask = delayed_i_q;
`else
  assign i_mask = i_flag;
`endif

  // The pin is sampled once, then compared with the sample before it, so a
  // falling edge reaches the latch on the second clock edge.
  assign nmi_edge = nmi_prev_q & ~nmi_sample_q;
  assign irq_req  = ~irq_n & ~i_mask;

  // A new edge wins over an acknowledge so an NMI arriving during vector
  // entry of the previous one is not lost.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      nmi_sample_q <= 1'b1;
      nmi_prev_q   <= 1'b1;
      nmi_latch_q  <= 1'b0;
      interrupt_q  <= 1'b0;
    end else begin
      nmi_sample_q <= nmi_n;
      nmi_prev_q   <= nmi_sample_q;
      if (nmi_edge) begin
        nmi_latch_q <= 1'b1;
      end else if (nmi_ack) begin
        nmi_latch_q <= 1'b0;
      end
      if (poll) begin
        interrupt_q <= nmi_latch_q | irq_req;
      end
    end
  end

  assign nmi_pending = nmi_latch_q;
  assign interrupt   = interrupt_q;

endmodule

// File: rtl/core_status.sv
// core_status
//   6502/2A03 processor status register. Latches ALU flags (fed straight
//   back to the ALU next cycle), executes flag opcodes and PLP/RTI loads,
//   forms the push byte, evaluates branch conditions and hosts the
//   interrupt sampler (core_status_irq, which honours the optional macro
//   CORE_STATUS_IRQ_DELAY_EN).
//
// Ports:
//   I_clock, I_reset_n          clock, synchronous active-low reset
//   I_control                   load_alu, load_bus, set_i, flag_op
//   I_alu_carry/zero/sign/overflow  ALU flag results
//   I_data                      bus byte for PLP/RTI
//   I_push_brk                  B bit of the push byte
//   I_branch_cond               branch opcode bits [7:5]
//   I_nmi_n, I_irq_n            interrupt pins
//   I_poll, I_nmi_ack           instruction boundary, NMI acknowledge
//   O_carry/zero/sign/overflow  registered flags to the ALU
//   O_interrupt_disable, O_decimal  registered I and D
//   O_status                    push byte {N,V,1,B,D,I,Z,C}
//   O_branch_taken              branch condition result
//   O_nmi_pending, O_interrupt  NMI latch, interrupt request
module core_status
  import core_status_signals::*;
(
  input  logic               I_clock,
  input  logic               I_reset_n,
  input  status_control_type I_control,
  input  logic               I_alu_carry,
  input  logic               I_alu_zero,
  input  logic               I_alu_sign,
  input  logic               I_alu_overflow,
  input  logic [7:0]         I_data,
  input  logic               I_push_brk,
  input  logic [2:0]         I_branch_cond,
  input  logic               I_nmi_n,
  input  logic               I_irq_n,
  input  logic               I_poll,
  input  logic               I_nmi_ack,
  output logic               O_carry,
  output logic               O_zero,
  output logic               O_sign,
  output logic               O_overflow,
  output logic               O_interrupt_disable,
  output logic               O_decimal,
  output logic [7:0]         O_status,
  output logic               O_branch_taken,
  output logic               O_nmi_pending,
  output logic               O_interrupt
);

  logic carry_q, zero_q, irq_disable_q, decimal_q, overflow_q, sign_q;
  logic carry_d, zero_d, irq_disable_d, decimal_d, overflow_d, sign_d;
  logic branch_flag;
  logic unused_data_bits;

  // B and bit 5 have no storage in P, so those bus bits are dropped.
  assign unused_data_bits = ^I_data[5:4];

  // Each flag resolves its own priority chain: set_i (I only), then a bus
  // load, then the flag opcode aimed at it, then the ALU result.
  always_comb begin
    carry_d       = carry_q;
    zero_d        = zero_q;
    irq_disable_d = irq_disable_q;
    decimal_d     = decimal_q;
    overflow_d    = overflow_q;
    sign_d        = sign_q;

    if (I_control.load_bus)                    carry_d = I_data[STATUS_C];
    else if (I_control.flag_op == FLAG_OP_CLC) carry_d = 1'b0;
    else if (I_control.flag_op == FLAG_OP_SEC) carry_d = 1'b1;
    else if (I_control.load_alu)               carry_d = I_alu_carry;

    if (I_control.load_bus)                    zero_d = I_data[STATUS_Z];
    else if (I_control.load_alu)               zero_d = I_alu_zero;

    if (I_control.set_i)                       irq_disable_d = 1'b1;
    else if (I_control.load_bus)               irq_disable_d = I_data[STATUS_I];
    else if (I_control.flag_op == FLAG_OP_CLI) irq_disable_d = 1'b0;
    else if (I_control.flag_op == FLAG_OP_SEI) irq_disable_d = 1'b1;

    if (I_control.load_bus)                    decimal_d = I_data[STATUS_D];
    else if (I_control.flag_op == FLAG_OP_CLD) decimal_d = 1'b0;
    else if (I_control.flag_op == FLAG_OP_SED) decimal_d = 1'b1;

    if (I_control.load_bus)                    overflow_d = I_data[STATUS_V];
    else if (I_control.flag_op == FLAG_OP_CLV) overflow_d = 1'b0;
    else if (I_control.load_alu)               overflow_d = I_alu_overflow;

    if (I_control.load_bus)                    sign_d = I_data[STATUS_N];
    else if (I_control.load_alu)               sign_d = I_alu_sign;
  end

  always_ff @(posedge I_clock) begin
    if (!I_reset_n) begin
      carry_q       <= 1'b0;
      zero_q        <= 1'b0;
      irq_disable_q <= 1'b1;
      decimal_q     <= 1'b0;
      overflow_q    <= 1'b0;
      sign_q        <= 1'b0;
    end else begin
      carry_q       <= carry_d;
      zero_q        <= zero_d;
      irq_disable_q <= irq_disable_d;
      decimal_q     <= decimal_d;
      overflow_q    <= overflow_d;
      sign_q        <= sign_d;
    end
  end

  // Branch opcode bits [7:6] choose the flag, bit 5 the value that takes it.
  always_comb begin
    branch_flag = sign_q;
    case (branch_sel_type'(I_branch_cond[2:1]))
      BRANCH_SEL_N: branch_flag = sign_q;
      BRANCH_SEL_V: branch_flag = overflow_q;
      BRANCH_SEL_C: branch_flag = carry_q;
      BRANCH_SEL_Z: branch_flag = zero_q;
      default:      branch_flag = sign_q;
    endcase
  end

  assign O_branch_taken = (branch_flag == I_branch_cond[0]);

  assign O_status = pack_status(sign_q, overflow_q, I_push_brk, decimal_q,
                                irq_disable_q, zero_q, carry_q);

  assign O_carry             = carry_q;
  assign O_zero              = zero_q;
  assign O_sign              = sign_q;
  assign O_overflow          = overflow_q;
  assign O_interrupt_disable = irq_disable_q;
  assign O_decimal           = decimal_q;

  core_status_irq u_irq (
    .clock       (I_clock),
    .reset_n     (I_reset_n),
    .nmi_n       (I_nmi_n),
    .irq_n       (I_irq_n),
    .poll        (I_poll),
    .nmi_ack     (I_nmi_ack),
    .i_flag      (irq_disable_q),
    .nmi_pending (O_nmi_pending),
    .interrupt   (O_interrupt)
  );

endmodule

// File: tb/tb_core_status.sv
module tb_core_status;
  import core_status_signals::*;

`ifdef CORE_STATUS_IRQ_DELAY_EN
  localparam bit IRQ_DELAY = 1'b1;
`else
  localparam bit IRQ_DELAY = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               reset_n;
  status_control_type ctrl;
  logic               alu_c, alu_z, alu_s, alu_v;
  logic [7:0]         data;
  logic               push_brk;
  logic [2:0]         branch_cond;
  logic               nmi_n, irq_n, poll, nmi_ack;
  logic               o_carry, o_zero, o_sign, o_overflow, o_idis, o_dec;
  logic [7:0]         o_status;
  logic               o_branch, o_nmi_pending, o_interrupt;

  int checks   = 0;
  int failures = 0;

  core_status dut (
    .I_clock             (clock),
    .I_reset_n           (reset_n),
    .I_control           (ctrl),
    .I_alu_carry         (alu_c),
    .I_alu_zero          (alu_z),
    .I_alu_sign          (alu_s),
    .I_alu_overflow      (alu_v),
    .I_data              (data),
    .I_push_brk          (push_brk),
    .I_branch_cond       (branch_cond),
    .I_nmi_n             (nmi_n),
    .I_irq_n             (irq_n),
    .I_poll              (poll),
    .I_nmi_ack           (nmi_ack),
    .O_carry             (o_carry),
    .O_zero              (o_zero),
    .O_sign              (o_sign),
    .O_overflow          (o_overflow),
    .O_interrupt_disable (o_idis),
    .O_decimal           (o_dec),
    .O_status            (o_status),
    .O_branch_taken      (o_branch),
    .O_nmi_pending       (o_nmi_pending),
    .O_interrupt         (o_interrupt)
  );

  always #5 clock = ~clock;

  // Reference model: P kept as a byte in push-byte bit order (bits 5:4 zero).
  logic [7:0] m_p;
  bit         m_hist[$];
  logic       m_latch, m_int, m_di;
  bit         m_valid = 1'b0;

  always @(posedge clock) begin
    logic [7:0] nxt;
    logic       edge_now, mask;
    if (!reset_n) begin
      m_p     = 8'h04;
      m_hist  = '{1'b1, 1'b1};
      m_latch = 1'b0;
      m_int   = 1'b0;
      m_di    = 1'b1;
      m_valid = 1'b1;
    end else if (m_valid) begin
      // Apply writers lowest priority first so higher ones overwrite.
      nxt = m_p;
      if (ctrl.load_alu) begin
        nxt[0] = alu_c; nxt[1] = alu_z; nxt[6] = alu_v; nxt[7] = alu_s;
      end
      case (ctrl.flag_op)
        FLAG_OP_CLC: nxt[0] = 1'b0;
        FLAG_OP_SEC: nxt[0] = 1'b1;
        FLAG_OP_CLI: nxt[2] = 1'b0;
        FLAG_OP_SEI: nxt[2] = 1'b1;
        FLAG_OP_CLD: nxt[3] = 1'b0;
        FLAG_OP_SED: nxt[3] = 1'b1;
        FLAG_OP_CLV: nxt[6] = 1'b0;
        default: ;
      endcase
      if (ctrl.load_bus) nxt = data & 8'hCF;
      if (ctrl.set_i) nxt[2] = 1'b1;

      edge_now = m_hist[m_hist.size()-2] && !m_hist[m_hist.size()-1];
      mask = IRQ_DELAY ? m_di : m_p[2];
      if (poll) begin
        m_int = m_latch | (!irq_n && !mask);
        m_di  = m_p[2];
      end
      if (edge_now) m_latch = 1'b1;
      else if (nmi_ack) m_latch = 1'b0;
      m_hist.push_back(nmi_n);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      m_p = nxt;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Advance n clock edges with the current inputs, then settle past the edge.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic setIdle();
    ctrl        = status_control_type'(6'b0);
    alu_c       = 1'b0; alu_z = 1'b0; alu_s = 1'b0; alu_v = 1'b0;
    data        = 8'h00;
    push_brk    = 1'b0;
    branch_cond = 3'b000;
    poll        = 1'b0;
    nmi_ack     = 1'b0;
    #1;
  endtask

  // Model-vs-DUT comparison on every falling edge once reset has been seen.
  always @(negedge clock) begin
    logic [7:0] exp_status;
    logic       flag;
    if (m_valid) begin
      exp_status = m_p | 8'h20 | (push_brk ? 8'h10 : 8'h00);
      checkOutput("model_status", o_status, exp_status);
      checkOutput("model_flags",
                  {2'b00, o_sign, o_overflow, o_dec, o_idis, o_zero, o_carry},
                  {2'b00, m_p[7], m_p[6], m_p[3], m_p[2], m_p[1], m_p[0]});
      case (branch_cond[2:1])
        2'd0:    flag = m_p[7];
        2'd1:    flag = m_p[6];
        2'd2:    flag = m_p[0];
        default: flag = m_p[1];
      endcase
      checkOutput("model_branch", {7'b0, o_branch}, {7'b0, flag == branch_cond[0]});
      checkOutput("model_nmi", {7'b0, o_nmi_pending}, {7'b0, m_latch});
      checkOutput("model_interrupt", {7'b0, o_interrupt}, {7'b0, m_int});
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n = 1'b0;
    nmi_n   = 1'b1;
    irq_n   = 1'b1;
    setIdle();
    applyStimulus(2);
    reset_n = 1'b1;
    checkOutput("reset_status", o_status, 8'h24);
    checkOutput("reset_interrupt", {7'b0, o_interrupt}, 8'h00);
    checkOutput("reset_nmi", {7'b0, o_nmi_pending}, 8'h00);

    ctrl.load_alu = 1'b1;
    alu_c = 1'b1; alu_z = 1'b0; alu_s = 1'b1; alu_v = 1'b1;
    applyStimulus(1);
    setIdle();
    checkOutput("alu_flags", {4'b0, o_sign, o_overflow, o_zero, o_carry}, 8'h0D);
    checkOutput("alu_status", o_status, 8'hE5);

    ctrl.load_bus = 1'b1; data = 8'hFF;
    applyStimulus(1);
    setIdle();
    checkOutput("plp_status", o_status, 8'hEF);
    ctrl.flag_op = FLAG_OP_CLV;
    applyStimulus(1);
    setIdle();
    checkOutput("clv_status", o_status, 8'hAF);

    ctrl.set_i = 1'b1; ctrl.load_bus = 1'b1; data = 8'h00;
    applyStimulus(1);
    setIdle();
    checkOutput("seti_over_bus", o_status, 8'h24);
    ctrl.flag_op = FLAG_OP_SEC; ctrl.load_alu = 1'b1; alu_c = 1'b0;
    applyStimulus(1);
    setIdle();
    checkOutput("sec_over_alu", o_status, 8'h25);
    push_brk = 1'b1; #1;
    checkOutput("push_brk_status", o_status, 8'h35);
    push_brk = 1'b0;

    branch_cond = 3'b101; #1;
    checkOutput("bcs_taken", {7'b0, o_branch}, 8'h01);
    branch_cond = 3'b111; #1;
    checkOutput("beq_not_taken", {7'b0, o_branch}, 8'h00);
    branch_cond = 3'b110; #1;
    checkOutput("bne_taken", {7'b0, o_branch}, 8'h01);
    branch_cond = 3'b001; #1;
    checkOutput("bmi_not_taken", {7'b0, o_branch}, 8'h00);
    branch_cond = 3'b000;

    nmi_n = 1'b0;
    applyStimulus(1);
    checkOutput("nmi_after_1_edge", {7'b0, o_nmi_pending}, 8'h00);
    applyStimulus(1);
    checkOutput("nmi_after_2_edges", {7'b0, o_nmi_pending}, 8'h01);
    poll = 1'b1;
    applyStimulus(1);
    poll = 1'b0;
    checkOutput("nmi_interrupt", {7'b0, o_interrupt}, 8'h01);
    nmi_ack = 1'b1;
    applyStimulus(1);
    nmi_ack = 1'b0;
    checkOutput("nmi_ack_clears", {7'b0, o_nmi_pending}, 8'h00);
    poll = 1'b1;
    applyStimulus(1);
    poll = 1'b0;
    checkOutput("interrupt_dropped", {7'b0, o_interrupt}, 8'h00);

    nmi_n = 1'b1; irq_n = 1'b0;
    ctrl.flag_op = FLAG_OP_CLI;
    applyStimulus(1);
    setIdle();
    checkOutput("cli_clears_i", {7'b0, o_idis}, 8'h00);
    poll = 1'b1;
    applyStimulus(1);
    poll = 1'b0;
    checkOutput("irq_first_poll", {7'b0, o_interrupt}, IRQ_DELAY ? 8'h00 : 8'h01);
    poll = 1'b1;
    applyStimulus(1);
    poll = 1'b0;
    checkOutput("irq_second_poll", {7'b0, o_interrupt}, 8'h01);

    for (int n = 0; n < 800; n++) begin
      reset_n        = ($urandom_range(0, 59) != 0);
      ctrl.load_alu  = 1'($urandom_range(0, 1));
      ctrl.load_bus  = ($urandom_range(0, 3) == 0);
      ctrl.set_i     = ($urandom_range(0, 5) == 0);
      ctrl.flag_op   = flag_op_type'($urandom_range(0, 7));
      alu_c          = 1'($urandom_range(0, 1));
      alu_z          = 1'($urandom_range(0, 1));
      alu_s          = 1'($urandom_range(0, 1));
      alu_v          = 1'($urandom_range(0, 1));
      data           = 8'($urandom);
      push_brk       = 1'($urandom_range(0, 1));
      branch_cond    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) nmi_n = ~nmi_n;
      irq_n          = 1'($urandom_range(0, 1));
      poll           = ($urandom_range(0, 2) == 0);
      nmi_ack        = ($urandom_range(0, 7) == 0);
      applyStimulus(1);
    end

    reset_n = 1'b1;
    setIdle();
    applyStimulus(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
